// File: rtl/picorv32_mem_responder_if.sv
// PicoRV32 native memory bus bundle: request from the core, completion from memory.
interface picorv32_mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Core side drives the request and waits for the completion strobe.
    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    // Memory side receives the request and returns the completion strobe.
    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Memory-side responder for the PicoRV32 native bus: a word RAM window with
// programmable wait states, an external stall, byte-strobe writes, saturating
// access counters and sticky flags for protocol and range errors.
module picorv32_mem_responder #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    picorv32_mem_responder_if.slave        mem,
    input  logic                           stall,
    output logic                           bus_err,
    output logic                           proto_err,
    output logic [15:0]                    if_count,
    output logic [15:0]                    rd_count,
    output logic [15:0]                    wr_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int unsigned WORDS    = 2 ** ADDR_BITS;

    // Only these strobe patterns can be produced by byte/half/word stores.
    function automatic logic wstrb_legal(input logic [3:0] s);
        case (s)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Replace only the strobed byte lanes of the old word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        proto_err_q, proto_err_d;
    logic [15:0] if_cnt_q, if_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    logic [31:0] ram_q [WORDS];

    // Window decode works on word addresses; BASE_ADDR is window-aligned, so
    // the low two byte-address bits never take part in indexing.
    logic [29:0]          off_w;
    logic                 in_win;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 ram_we;
    logic                 req_changed;

    assign off_w   = addr_q[31:2] - BASE_ADDR[31:2];
    assign in_win  = ((off_w >> ADDR_BITS) == 30'd0);
    assign ram_idx = off_w[ADDR_BITS-1:0];

    assign req_changed = (mem.mem_addr  != addr_q)  ||
                         (mem.mem_wstrb != wstrb_q) ||
                         (mem.mem_wdata != wdata_q);

    // Next-state logic: request capture, wait countdown, commit and protocol checks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        instr_d     = instr_q;
        ready_d     = ready_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        proto_err_d = proto_err_q;
        if_cnt_d    = if_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        ram_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b0;
                rdata_d = 32'h0;
                if (mem.mem_valid) begin
                    addr_d  = mem.mem_addr;
                    wdata_d = mem.mem_wdata;
                    wstrb_d = mem.mem_wstrb;
                    instr_d = mem.mem_instr;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!mem.mem_valid) begin
                    // Core withdrew the request: drop it without side effects.
                    proto_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    // Violations are flagged, but the latched request is what completes.
                    if (req_changed || !wstrb_legal(mem.mem_wstrb) ||
                        (mem.mem_addr[1:0] != 2'b00)) begin
                        proto_err_d = 1'b1;
                    end
                    if (!stall) begin
                        if (cnt_q != 4'd0) begin
                            cnt_d = cnt_q - 4'd1;
                        end else begin
                            ready_d = 1'b1;
                            state_d = ST_RESP;
                            if (!in_win) bus_err_d = 1'b1;
                            if (wstrb_q != 4'b0000) begin
                                rdata_d  = 32'h0;
                                ram_we   = in_win;
                                wr_cnt_d = sat_inc(wr_cnt_q);
                            end else begin
                                rdata_d = in_win ? ram_q[ram_idx] : ERR_RDATA;
                                if (instr_q) if_cnt_d = sat_inc(if_cnt_q);
                                else         rd_cnt_d = sat_inc(rd_cnt_q);
                            end
                        end
                    end
                end
            end

            ST_RESP: begin
                // One-cycle completion strobe; any pending request waits a bubble.
                ready_d = 1'b0;
                rdata_d = 32'h0;
                state_d = ST_IDLE;
            end

            default: begin
                ready_d = 1'b0;
                rdata_d = 32'h0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            instr_q     <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0;
            bus_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
            if_cnt_q    <= 16'h0;
            rd_cnt_q    <= 16'h0;
            wr_cnt_q    <= 16'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            instr_q     <= instr_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            proto_err_q <= proto_err_d;
            if_cnt_q    <= if_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    // RAM storage is not reset; writes only happen on a committing WAIT edge.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= merge_bytes(ram_q[ram_idx], wdata_q, wstrb_q);
        end
    end

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;
    assign bus_err       = bus_err_q;
    assign proto_err     = proto_err_q;
    assign if_count      = if_cnt_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench for picorv32_mem_responder with WAIT_CYCLES=1.
module tb_picorv32_mem_responder;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        bus_err;
    logic        proto_err;
    logic [15:0] if_count;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int checks;
    int errors;

    picorv32_mem_responder_if bus ();

    picorv32_mem_responder #(
        .ADDR_BITS   (10),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (1),
        .ERR_RDATA   (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem       (bus),
        .stall     (stall),
        .bus_err   (bus_err),
        .proto_err (proto_err),
        .if_count  (if_count),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request from IDLE at a falling edge, count rising edges until
    // mem_ready is seen, drop valid, and sample ready one cycle later.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr,
                          output int lat, output logic [31:0] rdata,
                          output logic ready_after);
        lat   = -1;
        rdata = 32'hX;
        bus.mem_valid = 1'b1;
        bus.mem_instr = instr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_ready) begin
                lat   = n;
                rdata = bus.mem_rdata;
                break;
            end
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        bus.mem_instr = 1'b0;
        @(negedge clk);
        ready_after = bus.mem_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.mem_ready); end
        checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 00000000", bus.mem_rdata); end
        checks++; if ({bus_err, proto_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus_err, proto_err}); end
        checks++; if ({if_count, rd_count, wr_count} !== 48'h0) begin errors++; $display("FAIL reset_counts got %h want 0", {if_count, rd_count, wr_count}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic ra;
        do_req(32'h10, 32'hA5A5_5A5A, 4'b1111, 1'b0, lat, rd, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 00000000", rd); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b want 0", ra); end
        do_req(32'h10, 32'h0, 4'b0000, 1'b0, lat, rd, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'hA5A5_5A5A) begin errors++; $display("FAIL rd_data got %h want a5a55a5a", rd); end
        checks++; if (wr_count !== 16'd1 || rd_count !== 16'd1) begin errors++; $display("FAIL wr_rd_counts got wr=%0d rd=%0d want 1 1", wr_count, rd_count); end
    endtask

    task automatic test_byte_strobe();
        int lat; logic [31:0] rd; logic ra;
        do_req(32'h10, 32'h0000_CC00, 4'b0010, 1'b0, lat, rd, ra);
        do_req(32'h10, 32'h0, 4'b0000, 1'b0, lat, rd, ra);
        checks++; if (rd !== 32'hA5A5_CC5A) begin errors++; $display("FAIL strobe_merge got %h want a5a5cc5a", rd); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL strobe_proto got %b want 0", proto_err); end
    endtask

    task automatic test_instr_fetch();
        int lat; logic [31:0] rd; logic ra;
        do_req(32'h10, 32'h0, 4'b0000, 1'b1, lat, rd, ra);
        checks++; if (rd !== 32'hA5A5_CC5A) begin errors++; $display("FAIL ifetch_data got %h want a5a5cc5a", rd); end
        checks++; if (if_count !== 16'd1 || rd_count !== 16'd2) begin errors++; $display("FAIL ifetch_counts got if=%0d rd=%0d want 1 2", if_count, rd_count); end
    endtask

    task automatic test_stall();
        int lat; int extra;
        lat = -1; extra = 0;
        bus.mem_valid = 1'b1; bus.mem_instr = 1'b0;
        bus.mem_addr = 32'h10; bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'b0000;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_ready) begin lat = n; break; end
            // Stall covers exactly five WAIT edges (edges 2..6).
            stall = (n >= 1 && n <= 5);
        end
        stall = 1'b0;
        checks++; if (lat !== 8) begin errors++; $display("FAIL stall_latency got %0d want 8", lat); end
        checks++; if (bus.mem_rdata !== 32'hA5A5_CC5A) begin errors++; $display("FAIL stall_data got %h want a5a5cc5a", bus.mem_rdata); end
        bus.mem_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.mem_ready) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL stall_dup got %0d extra pulses want 0", extra); end
        checks++; if (rd_count !== 16'd3) begin errors++; $display("FAIL stall_count got %0d want 3", rd_count); end
    endtask

    task automatic test_back_to_back();
        int lat1; int gap;
        lat1 = -1; gap = -1;
        bus.mem_valid = 1'b1; bus.mem_instr = 1'b0;
        bus.mem_addr = 32'h30; bus.mem_wdata = 32'h0BAD_F00D; bus.mem_wstrb = 4'b1111;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.mem_ready) begin lat1 = n; break; end
        end
        // Next request presented immediately, during the RESP cycle.
        bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'b0000;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.mem_ready) begin gap = n; break; end
        end
        checks++; if (lat1 !== 3) begin errors++; $display("FAIL b2b_first got %0d want 3", lat1); end
        checks++; if (gap !== 4) begin errors++; $display("FAIL b2b_gap got %0d want 4", gap); end
        checks++; if (bus.mem_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_data got %h want 0badf00d", bus.mem_rdata); end
        bus.mem_valid = 1'b0;
        @(negedge clk);
        checks++; if (wr_count !== 16'd3 || rd_count !== 16'd4) begin errors++; $display("FAIL b2b_counts got wr=%0d rd=%0d want 3 4", wr_count, rd_count); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic ra;
        do_req(32'h0, 32'h1234_5678, 4'b1111, 1'b0, lat, rd, ra);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL oor_pre got %b want 0", bus_err); end
        do_req(32'h1000, 32'h0, 4'b0000, 1'b0, lat, rd, ra);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_rdata got %h want deadbeef", rd); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL oor_flag got %b want 1", bus_err); end
        do_req(32'h1000, 32'hFFFF_FFFF, 4'b1111, 1'b0, lat, rd, ra);
        do_req(32'h0, 32'h0, 4'b0000, 1'b0, lat, rd, ra);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL oor_write_dropped got %h want 12345678", rd); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b want 1", bus_err); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL oor_proto got %b want 0", proto_err); end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd; logic ra; int seen;
        seen = 0;
        do_req(32'h20, 32'h1111_2222, 4'b1111, 1'b0, lat, rd, ra);
        checks++; if (wr_count !== 16'd6) begin errors++; $display("FAIL abort_pre_count got %0d want 6", wr_count); end
        bus.mem_valid = 1'b1; bus.mem_instr = 1'b0;
        bus.mem_addr = 32'h20; bus.mem_wdata = 32'h9999_9999; bus.mem_wstrb = 4'b1111;
        @(posedge clk); @(negedge clk);
        bus.mem_valid = 1'b0; bus.mem_wstrb = 4'b0000;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.mem_ready) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ready got %0d pulses want 0", seen); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL abort_proto got %b want 1", proto_err); end
        checks++; if (wr_count !== 16'd6) begin errors++; $display("FAIL abort_count got %0d want 6", wr_count); end
        do_req(32'h20, 32'h0, 4'b0000, 1'b0, lat, rd, ra);
        checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL abort_ram got %h want 11112222", rd); end
    endtask

    task automatic test_reset_in_resp();
        int lat; logic [31:0] rd; logic ra; logic seen;
        seen = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_instr = 1'b0;
        bus.mem_addr = 32'h10; bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'b0000;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.mem_ready) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_resp_reached got %b want 1", seen); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_out got ready=%b rdata=%h want 0 0", bus.mem_ready, bus.mem_rdata); end
        checks++; if ({bus_err, proto_err} !== 2'b00 || {if_count, rd_count, wr_count} !== 48'h0) begin errors++; $display("FAIL rst_resp_state got flags=%b counts=%h want 0", {bus_err, proto_err}, {if_count, rd_count, wr_count}); end
        bus.mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_req(32'h10, 32'h0, 4'b0000, 1'b0, lat, rd, ra);
        checks++; if (lat !== 3 || rd !== 32'hA5A5_CC5A) begin errors++; $display("FAIL rst_after got lat=%0d data=%h want 3 a5a5cc5a", lat, rd); end
        checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL rst_after_count got %0d want 1", rd_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        stall  = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'b0000;
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_instr_fetch();
        test_stall();
        test_back_to_back();
        test_out_of_range();
        test_abort();
        test_reset_in_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
